// File: rtl/life_gen_scheduler.sv
// life_gen_scheduler
//   Sequences the Game of Life board engine. Turns frame ticks, run/pause,
//   single-step and pattern-load buttons into step/load requests. The engine
//   is driven over two req/done handshakes, and load takes priority over step.
//   Also keeps the generation counter, a per-generation pulse and a sticky
//   overrun flag that records dropped step triggers.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   frame_tick            one-cycle pulse per video frame
//   run_en                1 = free-run, 0 = paused
//   step_btn, load_btn    debounced button levels (rising edge = trigger)
//   pat_sel [PAT_W]       pattern to load
//   speed   [DIV_W]       frames per generation minus 1
//   step_req / step_done  compute-one-generation handshake
//   load_req / load_done  load-pattern handshake, pattern on load_pat
//   busy                  a handshake is in progress
//   gen_pulse             one-cycle pulse per completed generation
//   gen_count [GEN_W]     generations since last load/reset
//   overrun               sticky, a step trigger was dropped
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | no request outstanding, serves pending flags
// STEP  | step_req high, waiting for step_done
// LOAD  | load_req high, waiting for load_done
module life_gen_scheduler #(
   parameter int DIV_W = 4,
   parameter int GEN_W = 16,
   parameter int PAT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_tick,
   input  logic             run_en,
   input  logic             step_btn,
   input  logic             load_btn,
   input  logic [PAT_W-1:0] pat_sel,
   input  logic [DIV_W-1:0] speed,
   output logic             step_req,
   input  logic             step_done,
   output logic             load_req,
   output logic [PAT_W-1:0] load_pat,
   input  logic             load_done,
   output logic             busy,
   output logic             gen_pulse,
   output logic [GEN_W-1:0] gen_count,
   output logic             overrun
);

   typedef enum logic [1:0] {IDLE, STEP, LOAD} state_t;

   state_t           state, state_nx;
   logic [DIV_W-1:0] frame_cnt, frame_cnt_nx;
   logic             pending_step, pending_step_nx;
   logic             pending_load, pending_load_nx;
   logic             step_prev, load_prev;
   logic             step_req_nx, load_req_nx, gen_pulse_nx, overrun_nx;
   logic [GEN_W-1:0] gen_count_nx;
   logic [PAT_W-1:0] load_pat_nx;

   logic div_hit, step_trig, load_edge;

   // >= rather than == so a speed lowered below the running count still fires.
   assign div_hit   = run_en && frame_tick && (frame_cnt >= speed);
   assign step_trig = div_hit || (!run_en && step_btn && !step_prev);
   assign load_edge = load_btn && !load_prev;

   always_comb begin
      state_nx        = state;
      step_req_nx     = step_req;
      load_req_nx     = load_req;
      gen_pulse_nx    = 1'b0;
      gen_count_nx    = gen_count;
      overrun_nx      = overrun;
      frame_cnt_nx    = frame_cnt;
      pending_step_nx = pending_step;
      pending_load_nx = pending_load;
      load_pat_nx     = load_pat;

      if (!run_en)
         frame_cnt_nx = '0;
      else if (frame_tick)
         frame_cnt_nx = div_hit ? '0 : frame_cnt + DIV_W'(1);

      case (state)
         IDLE: begin
            if (pending_load) begin
               state_nx        = LOAD;
               load_req_nx     = 1'b1;
               pending_load_nx = 1'b0;
               pending_step_nx = 1'b0;
            end else if (pending_step) begin
               state_nx        = STEP;
               step_req_nx     = 1'b1;
               pending_step_nx = 1'b0;
            end
         end
         STEP: begin
            if (step_done) begin
               state_nx     = IDLE;
               step_req_nx  = 1'b0;
               gen_count_nx = gen_count + GEN_W'(1);
               gen_pulse_nx = 1'b1;
            end
         end
         LOAD: begin
            if (load_done) begin
               state_nx     = IDLE;
               load_req_nx  = 1'b0;
               gen_count_nx = '0;
               overrun_nx   = 1'b0;
               frame_cnt_nx = '0;
            end
         end
         default: begin
            state_nx    = IDLE;
            step_req_nx = 1'b0;
            load_req_nx = 1'b0;
         end
      endcase

      // New triggers are applied after this cycle's service so a trigger that
      // lands on the consume edge is kept rather than counted as dropped.
      // A step colliding with a load edge is discarded by the load anyway, so
      // it never counts as an overrun.
      if (step_trig) begin
         if (!pending_step_nx)
            pending_step_nx = 1'b1;
         else if (!load_edge)
            overrun_nx = 1'b1;
      end
      if (load_edge) begin
         pending_load_nx = 1'b1;
         load_pat_nx     = pat_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         frame_cnt    <= '0;
         pending_step <= 1'b0;
         pending_load <= 1'b0;
         step_prev    <= step_btn;
         load_prev    <= load_btn;
         step_req     <= 1'b0;
         load_req     <= 1'b0;
         load_pat     <= '0;
         busy         <= 1'b0;
         gen_pulse    <= 1'b0;
         gen_count    <= '0;
         overrun      <= 1'b0;
      end else begin
         state        <= state_nx;
         frame_cnt    <= frame_cnt_nx;
         pending_step <= pending_step_nx;
         pending_load <= pending_load_nx;
         step_prev    <= step_btn;
         load_prev    <= load_btn;
         step_req     <= step_req_nx;
         load_req     <= load_req_nx;
         load_pat     <= load_pat_nx;
         busy         <= (state_nx != IDLE);
         gen_pulse    <= gen_pulse_nx;
         gen_count    <= gen_count_nx;
         overrun      <= overrun_nx;
      end
   end

endmodule
